// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle MIPS datapath: ALU operations, steering-mux
// selects and the memory-handshake sequencer states.
package mc_pkg;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_XOR = 3'b011;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] ALUSRCB_B     = 2'b00;
    localparam logic [1:0] ALUSRCB_FOUR  = 2'b01;
    localparam logic [1:0] ALUSRCB_IMM   = 2'b10;
    localparam logic [1:0] ALUSRCB_IMMSH = 2'b11;

    localparam logic [1:0] PCSRC_ALURESULT = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT    = 2'b01;
    localparam logic [1:0] PCSRC_JUMP      = 2'b10;
    localparam logic [1:0] PCSRC_REG       = 2'b11;

    localparam logic [1:0] REGDST_RT   = 2'b00;
    localparam logic [1:0] REGDST_RD   = 2'b01;
    localparam logic [1:0] REGDST_LINK = 2'b10;

    localparam logic [1:0] MEMTOREG_ALUOUT = 2'b00;
    localparam logic [1:0] MEMTOREG_MDR    = 2'b01;
    localparam logic [1:0] MEMTOREG_PC     = 2'b10;

    typedef enum logic [1:0] {
        SEQ_IDLE = 2'd0,
        SEQ_REQ  = 2'd1,
        SEQ_DONE = 2'd2
    } seq_state_t;

endpackage

// File: rtl/mc_regfile.sv
// General-purpose register file: two combinational read ports, one synchronous
// write port. r0 and indices at or above NREGS read as zero and ignore writes.
module mc_regfile #(
    parameter int WIDTH = 32,
    parameter int NREGS = 32
) (
    input  logic             clk,
    input  logic             we,
    input  logic [4:0]       ra1,
    input  logic [4:0]       ra2,
    input  logic [4:0]       wa,
    input  logic [WIDTH-1:0] wd,
    output logic [WIDTH-1:0] rd1,
    output logic [WIDTH-1:0] rd2
);

    localparam int AW = (NREGS > 1) ? $clog2(NREGS) : 1;

    logic [WIDTH-1:0] regs [NREGS];

    function automatic logic implemented(input logic [4:0] r);
        return (r != 5'd0) && (32'(r) < NREGS);
    endfunction

    // NOTE: the register array has no reset; clearing a memory would force it into
    // flops and software never relies on GPR contents at power-up.
    always_ff @(posedge clk) begin
        if (we && implemented(wa))
            regs[wa[AW-1:0]] <= wd;
    end

    assign rd1 = implemented(ra1) ? regs[ra1[AW-1:0]] : '0;
    assign rd2 = implemented(ra2) ? regs[ra2[AW-1:0]] : '0;

endmodule

// File: rtl/mc_datapath_hs.sv
// Multicycle MIPS datapath with an internal memory-handshake sequencer that lets the
// controller issue one transaction at a time against a variable-latency memory port.
module mc_datapath_hs
    import mc_pkg::*;
#(
    parameter int               WIDTH    = 32,
    parameter int               NREGS    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = '0,
    parameter logic [4:0]       LINK_REG = 5'd31
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pcen,
    input  logic             regwrite,
    input  logic             alusrca,
    input  logic [1:0]       alusrcb,
    input  logic [1:0]       pcsrc,
    input  logic [1:0]       regdst,
    input  logic [1:0]       memtoreg,
    input  logic             extop,
    input  logic [2:0]       alucontrol,
    input  logic             iord,
    input  logic             memstart,
    input  logic             memwrite,
    input  logic             irwrite,
    output logic             memdone,
    output logic             membusy,
    output logic [5:0]       op,
    output logic [5:0]       funct,
    output logic             zero,
    output logic             mem_req,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_adr,
    output logic [WIDTH-1:0] mem_wdata,
    input  logic             mem_ack,
    input  logic [WIDTH-1:0] mem_rdata
);

    logic [WIDTH-1:0] pc, instr, mdr, a, b, aluout;
    logic [WIDTH-1:0] rd1, rd2, immext, srca, srcb, aluresult, pcnext, wd;
    logic [4:0]       wa;
    logic             target_ir;
    seq_state_t       state;

    assign op    = instr[31:26];
    assign funct = instr[5:0];

    mc_regfile #(.WIDTH(WIDTH), .NREGS(NREGS)) u_regfile (
        .clk (clk),
        .we  (regwrite),
        .ra1 (instr[25:21]),
        .ra2 (instr[20:16]),
        .wa  (wa),
        .wd  (wd),
        .rd1 (rd1),
        .rd2 (rd2)
    );

    assign immext = extop ? {{(WIDTH-16){1'b0}}, instr[15:0]}
                          : {{(WIDTH-16){instr[15]}}, instr[15:0]};
    assign srca   = alusrca ? a : pc;

    // NOTE: every signal written in always_comb gets a default first so no path
    // through a case can leave it unassigned and infer a latch.
    always_comb begin
        srcb = b;
        case (alusrcb)
            ALUSRCB_FOUR:  srcb = WIDTH'(4);
            ALUSRCB_IMM:   srcb = immext;
            ALUSRCB_IMMSH: srcb = {immext[WIDTH-3:0], 2'b00};
            default:       srcb = b;
        endcase
    end

    always_comb begin
        aluresult = '0;
        case (alucontrol)
            ALU_AND: aluresult = srca & srcb;
            ALU_OR:  aluresult = srca | srcb;
            ALU_ADD: aluresult = srca + srcb;
            ALU_XOR: aluresult = srca ^ srcb;
            ALU_SUB: aluresult = srca - srcb;
            ALU_SLT: aluresult = {{(WIDTH-1){1'b0}}, $signed(srca) < $signed(srcb)};
            default: aluresult = '0;
        endcase
    end

    assign zero = (aluresult == '0);

    always_comb begin
        pcnext = aluresult;
        case (pcsrc)
            PCSRC_ALUOUT: pcnext = aluout;
            PCSRC_JUMP:   pcnext = {pc[WIDTH-1:28], instr[25:0], 2'b00};
            PCSRC_REG:    pcnext = a;
            default:      pcnext = aluresult;
        endcase
    end

    always_comb begin
        wa = instr[20:16];
        wd = aluout;
        case (regdst)
            REGDST_RD:   wa = instr[15:11];
            REGDST_LINK: wa = LINK_REG;
            default:     wa = instr[20:16];
        endcase
        case (memtoreg)
            MEMTOREG_MDR: wd = mdr;
            MEMTOREG_PC:  wd = pc;
            default:      wd = aluout;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge value of its inputs regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc     <= RESET_PC;
            a      <= '0;
            b      <= '0;
            aluout <= '0;
        end else begin
            a      <= rd1;
            b      <= rd2;
            aluout <= aluresult;
            if (pcen)
                pc <= pcnext;
        end
    end

    // Address, data and direction are captured at start so the controller may move
    // on while the memory stalls; the bus then stays stable until ack.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= SEQ_IDLE;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_adr   <= '0;
            mem_wdata <= '0;
            target_ir <= 1'b0;
            instr     <= '0;
            mdr       <= '0;
        end else begin
            case (state)
                SEQ_IDLE: begin
                    if (memstart) begin
                        mem_adr   <= iord ? aluout : pc;
                        mem_wdata <= b;
                        mem_we    <= memwrite;
                        target_ir <= irwrite;
                        mem_req   <= 1'b1;
                        state     <= SEQ_REQ;
                    end
                end
                SEQ_REQ: begin
                    if (mem_ack) begin
                        if (!mem_we) begin
                            if (target_ir)
                                instr <= mem_rdata;
                            else
                                mdr <= mem_rdata;
                        end
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        state   <= SEQ_DONE;
                    end
                end
                SEQ_DONE: state <= SEQ_IDLE;
                default:  state <= SEQ_IDLE;
            endcase
        end
    end

    assign memdone = (state == SEQ_DONE);
    assign membusy = (state != SEQ_IDLE);

endmodule

// File: tb/tb_mc_datapath_hs.sv
// Directed self-checking bench for mc_datapath_hs: reset, fetch with wait states,
// store, link/jr/jump, ALU edge cases, busy/reset handshake corners, reduced NREGS.
module tb_mc_datapath_hs;

    localparam logic [31:0] RST_PC = 32'h0040_0000;

    logic        clk = 1'b0;
    logic        reset, pcen, regwrite, alusrca, extop, iord, memstart, memwrite, irwrite;
    logic [1:0]  alusrcb, pcsrc, regdst, memtoreg;
    logic [2:0]  alucontrol;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    logic        memdone, membusy, zero, mem_req, mem_we;
    logic [5:0]  op, funct;
    logic [31:0] mem_adr, mem_wdata;

    logic        memdone_16, membusy_16, zero_16, mem_req_16, mem_we_16;
    logic [5:0]  op_16, funct_16;
    logic [31:0] mem_adr_16, mem_wdata_16;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mc_datapath_hs #(.WIDTH(32), .NREGS(32), .RESET_PC(RST_PC), .LINK_REG(5'd31)) dut (
        .clk(clk), .reset(reset), .pcen(pcen), .regwrite(regwrite), .alusrca(alusrca),
        .alusrcb(alusrcb), .pcsrc(pcsrc), .regdst(regdst), .memtoreg(memtoreg),
        .extop(extop), .alucontrol(alucontrol), .iord(iord), .memstart(memstart),
        .memwrite(memwrite), .irwrite(irwrite), .memdone(memdone), .membusy(membusy),
        .op(op), .funct(funct), .zero(zero), .mem_req(mem_req), .mem_we(mem_we),
        .mem_adr(mem_adr), .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    mc_datapath_hs #(.WIDTH(32), .NREGS(16), .RESET_PC(RST_PC), .LINK_REG(5'd31)) dut16 (
        .clk(clk), .reset(reset), .pcen(pcen), .regwrite(regwrite), .alusrca(alusrca),
        .alusrcb(alusrcb), .pcsrc(pcsrc), .regdst(regdst), .memtoreg(memtoreg),
        .extop(extop), .alucontrol(alucontrol), .iord(iord), .memstart(memstart),
        .memwrite(memwrite), .irwrite(irwrite), .memdone(memdone_16), .membusy(membusy_16),
        .op(op_16), .funct(funct_16), .zero(zero_16), .mem_req(mem_req_16), .mem_we(mem_we_16),
        .mem_adr(mem_adr_16), .mem_wdata(mem_wdata_16), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One complete transaction: start, waits, ack, DONE, back to IDLE.
    task automatic mem_txn(input logic t_iord, input logic t_ir, input logic t_we,
                           input int waits, input logic [31:0] rdata);
        iord = t_iord; irwrite = t_ir; memwrite = t_we; memstart = 1'b1;
        tick();
        memstart = 1'b0;
        repeat (waits) tick();
        mem_ack = 1'b1; mem_rdata = rdata;
        tick();
        mem_ack = 1'b0; mem_rdata = '0; memwrite = 1'b0;
        tick();
    endtask

    // Fetch an instruction whose rt names the target, load the value into MDR, write rt.
    task automatic write_reg(input logic [31:0] rt_instr, input logic [31:0] val);
        mem_txn(1'b0, 1'b1, 1'b0, 0, rt_instr);
        mem_txn(1'b0, 1'b0, 1'b0, 0, val);
        regdst = 2'b00; memtoreg = 2'b01; regwrite = 1'b1;
        tick();
        regwrite = 1'b0; memtoreg = 2'b00;
    endtask

    // r1 = av, r2 = bv, IR left as add r3,r1,r2 so A = r1 and B = r2.
    task automatic set_ab(input logic [31:0] av, input logic [31:0] bv);
        write_reg(32'h0001_0000, av);
        write_reg(32'h0022_1820, bv);
        tick();
    endtask

    initial begin
        reset = 1'b1; pcen = 1'b0; regwrite = 1'b0; alusrca = 1'b0; extop = 1'b0;
        iord = 1'b0; memstart = 1'b0; memwrite = 1'b0; irwrite = 1'b0;
        alusrcb = 2'b00; pcsrc = 2'b00; regdst = 2'b00; memtoreg = 2'b00;
        alucontrol = 3'b000; mem_ack = 1'b0; mem_rdata = '0;

        // Reset
        tick(); tick();
        check("rst_pc", dut.pc, RST_PC);
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_membusy", 32'(membusy), 32'd0);
        check("rst_memdone", 32'(memdone), 32'd0);
        check("rst_ir", dut.instr, 32'd0);
        reset = 1'b0;
        tick();

        // Fetch with three wait states
        iord = 1'b0; irwrite = 1'b1; memwrite = 1'b0; memstart = 1'b1;
        tick();
        memstart = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            check($sformatf("fetch_req_%0d", i), 32'(mem_req), 32'd1);
            check($sformatf("fetch_adr_%0d", i), mem_adr, RST_PC);
            check($sformatf("fetch_nodone_%0d", i), 32'(memdone), 32'd0);
            mem_ack   = (i == 4);
            mem_rdata = (i == 4) ? 32'h2008_0005 : 32'hFFFF_FFFF;
            tick();
        end
        mem_ack = 1'b0;
        check("fetch_done_at_5", 32'(memdone), 32'd1);
        check("fetch_req_drop", 32'(mem_req), 32'd0);
        check("fetch_ir", dut.instr, 32'h2008_0005);
        check("fetch_op", 32'(op), 32'h08);
        check("fetch_funct", 32'(funct), 32'h05);
        tick();
        check("fetch_done_once", 32'(memdone), 32'd0);
        check("fetch_idle", 32'(membusy), 32'd0);

        // Load 0xDEADBEEF into MDR, write r8, fetch an instruction with imm 0x10
        mem_txn(1'b0, 1'b0, 1'b0, 1, 32'hDEAD_BEEF);
        check("load_mdr", dut.mdr, 32'hDEAD_BEEF);
        check("load_ir_kept", dut.instr, 32'h2008_0005);
        regdst = 2'b00; memtoreg = 2'b01; regwrite = 1'b1;
        tick();
        regwrite = 1'b0; memtoreg = 2'b00;
        mem_txn(1'b0, 1'b1, 1'b0, 0, 32'h2008_0010);

        // Store with zero-wait ack: ALUOut = 0 + (0x10 << 2) = 0x40, B = r8
        alusrca = 1'b1; alusrcb = 2'b11; alucontrol = 3'b010;
        tick();
        iord = 1'b1; irwrite = 1'b0; memwrite = 1'b1; memstart = 1'b1;
        tick();
        memstart = 1'b0;
        check("st_req", 32'(mem_req), 32'd1);
        check("st_we", 32'(mem_we), 32'd1);
        check("st_adr", mem_adr, 32'h0000_0040);
        check("st_wdata", mem_wdata, 32'hDEAD_BEEF);
        mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
        tick();
        mem_ack = 1'b0; memwrite = 1'b0;
        check("st_done", 32'(memdone), 32'd1);
        check("st_ir_kept", dut.instr, 32'h2008_0010);
        check("st_mdr_kept", dut.mdr, 32'hDEAD_BEEF);
        tick();

        // PC + 4 four times, then jal link, jr back, and a jump
        alusrca = 1'b0; alusrcb = 2'b01; alucontrol = 3'b010; pcsrc = 2'b00; pcen = 1'b1;
        repeat (4) tick();
        pcen = 1'b0;
        check("pc_inc", dut.pc, 32'h0040_0010);
        regdst = 2'b10; memtoreg = 2'b10; regwrite = 1'b1;
        tick();
        regwrite = 1'b0; regdst = 2'b00; memtoreg = 2'b00;
        mem_txn(1'b0, 1'b1, 1'b0, 0, 32'h03E0_0008);
        check("jr_funct", 32'(funct), 32'h08);
        pcen = 1'b1;
        tick();
        pcen = 1'b0;
        check("pc_moved", dut.pc, 32'h0040_0014);
        check("a_r31", dut.a, 32'h0040_0010);
        pcsrc = 2'b11; pcen = 1'b1;
        tick();
        check("jr_pc", dut.pc, 32'h0040_0010);
        pcsrc = 2'b10;
        tick();
        pcen = 1'b0; pcsrc = 2'b00;
        check("jump_pc", dut.pc, 32'h0F80_0020);

        // ALU edges
        set_ab(32'h7FFF_FFFF, 32'h0000_0001);
        alusrca = 1'b1; alusrcb = 2'b00; alucontrol = 3'b010;
        #1;
        check("add_ovf", dut.aluresult, 32'h8000_0000);
        check("add_ovf_zero", 32'(zero), 32'd0);
        tick();
        check("aluout_latch", dut.aluout, 32'h8000_0000);
        alucontrol = 3'b011;
        #1;
        check("xor", dut.aluresult, 32'h7FFF_FFFE);
        alucontrol = 3'b100;
        #1;
        check("undef_op", dut.aluresult, 32'h0000_0000);
        set_ab(32'hFFFF_FFFF, 32'h0000_0001);
        alucontrol = 3'b111;
        #1;
        check("slt_neg", dut.aluresult, 32'h0000_0001);
        set_ab(32'h0000_0005, 32'h0000_0005);
        alucontrol = 3'b110;
        #1;
        check("sub_eq", dut.aluresult, 32'h0000_0000);
        check("sub_zero", 32'(zero), 32'd1);
        mem_txn(1'b0, 1'b1, 1'b0, 0, 32'h2008_FFFF);
        alusrca = 1'b1; alusrcb = 2'b10; alucontrol = 3'b010; extop = 1'b1;
        #1;
        check("zext", dut.aluresult, 32'h0000_FFFF);
        extop = 1'b0;
        #1;
        check("sext", dut.aluresult, 32'hFFFF_FFFF);

        // memstart while busy is ignored; aluout (0xFFFF) differs from PC
        extop = 1'b1;
        tick();
        iord = 1'b0; irwrite = 1'b0; memwrite = 1'b0; memstart = 1'b1;
        tick();
        check("busy_adr0", mem_adr, 32'h0F80_0020);
        iord = 1'b1;
        tick();
        check("busy_req", 32'(mem_req), 32'd1);
        check("busy_adr1", mem_adr, 32'h0F80_0020);
        mem_ack = 1'b1; mem_rdata = 32'hCAFE_F00D;
        tick();
        mem_ack = 1'b0;
        check("busy_done", 32'(memdone), 32'd1);
        tick();
        memstart = 1'b0;
        check("busy_idle", 32'(membusy), 32'd0);
        check("busy_no_req", 32'(mem_req), 32'd0);
        check("busy_mdr", dut.mdr, 32'hCAFE_F00D);
        tick();
        check("busy_no_second", 32'(mem_req), 32'd0);

        // Reset in REQ with a simultaneous ack
        iord = 1'b0; irwrite = 1'b1; memstart = 1'b1;
        tick();
        memstart = 1'b0;
        check("rreq_req", 32'(mem_req), 32'd1);
        reset = 1'b1; mem_ack = 1'b1; mem_rdata = 32'hBAD0_BAD0;
        tick();
        mem_ack = 1'b0; mem_rdata = '0;
        check("rreq_req_drop", 32'(mem_req), 32'd0);
        check("rreq_no_done", 32'(memdone), 32'd0);
        check("rreq_idle", 32'(membusy), 32'd0);
        check("rreq_ir", dut.instr, 32'd0);
        check("rreq_pc", dut.pc, RST_PC);
        reset = 1'b0;
        tick();
        check("rreq_no_done_after", 32'(memdone), 32'd0);

        // r20 exists with 32 GPRs, not with 16
        write_reg(32'h0294_0000, 32'h0000_0055);
        tick();
        check("r20_n32", dut.a, 32'h0000_0055);
        check("r20_n16", dut16.a, 32'h0000_0000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
